if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline: PC register, word-organised instruction ROM, IF/ID pipeline register.
- Feeds the decode stage (instruction_id, pc_id, pc_plus4_id).
- Consumes stall controls (pc_write, if_id_write) from the hazard unit and redirect/flush controls (pc_src, branch_target, if_id_flush) from EX.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/instruction_memory.sv | 29 ++
 rtl/if_stage.sv | 72 +++++++
 tb/tb_if_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline constants and the IF/ID bundle
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h00000000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  function automatic if_id_t make_if_id(input logic [XLEN-1:0] instr,
                                        input logic [XLEN-1:0] pc,
                                        input logic            valid);
    if_id_t r;
    r.instr    = instr;
    r.pc       = pc;
    r.pc_plus4 = pc + 32'd4;
    r.valid    = valid;
    return r;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word-organised combinational instruction ROM
module instruction_memory #(
  parameter int                       IMEM_DEPTH = 64,
  parameter logic [31:0]              NOP_INSTR  = riscv_pkg::NOP_INSTR,
  parameter logic [32*IMEM_DEPTH-1:0] IMEM_INIT  = {IMEM_DEPTH{NOP_INSTR}}
) (
  input  logic [31:0] addr,
  output logic [31:0] data
);

  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [31:0] rom [IMEM_DEPTH];
  logic [29:0] word_idx;
  logic        in_range;
  logic        unused_byte_bits;

  for (genvar i = 0; i < IMEM_DEPTH; i++) begin : g_rom
    assign rom[i] = IMEM_INIT[i*32 +: 32];
  end

  // Range test uses the full word index so high addresses never alias low words.
  assign word_idx         = addr[31:2];
  assign in_range         = (word_idx < 30'(IMEM_DEPTH));
  assign unused_byte_bits = ^addr[1:0];

  assign data = in_range ? rom[addr[AW+1:2]] : NOP_INSTR;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC register, ROM and IF/ID register
module if_stage #(
  parameter int                       IMEM_DEPTH = 64,
  parameter logic [31:0]              RESET_PC   = riscv_pkg::RESET_PC,
  parameter logic [31:0]              NOP_INSTR  = riscv_pkg::NOP_INSTR,
  parameter logic [32*IMEM_DEPTH-1:0] IMEM_INIT  = {IMEM_DEPTH{NOP_INSTR}}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        if_id_flush,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_current,
  output logic [31:0] instruction_if,
  output logic [31:0] pc_id,
  output logic [31:0] pc_plus4_id,
  output logic [31:0] instruction_id,
  output logic        valid_id,
  output logic [31:0] fetch_count
);

  import riscv_pkg::*;

  if_id_t if_id;
  logic   unused_target_bits;

  assign unused_target_bits = ^branch_target[1:0];

  instruction_memory #(
    .IMEM_DEPTH(IMEM_DEPTH),
    .NOP_INSTR (NOP_INSTR),
    .IMEM_INIT (IMEM_INIT)
  ) u_imem (
    .addr(pc_current),
    .data(instruction_if)
  );

  // A redirect from EX wins over a hazard stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_current <= RESET_PC;
    end else if (pc_src) begin
      pc_current <= {branch_target[31:2], 2'b00};
    end else if (pc_write) begin
      pc_current <= pc_current + 32'd4;
    end
  end

  // A flush inserts a bubble but keeps pc_id/pc_plus4_id of the squashed slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id       <= make_if_id(NOP_INSTR, 32'd0, 1'b0);
      fetch_count <= 32'd0;
    end else if (if_id_flush) begin
      if_id.instr <= NOP_INSTR;
      if_id.valid <= 1'b0;
    end else if (if_id_write) begin
      if_id <= make_if_id(instruction_if, pc_current, 1'b1);
      if (fetch_count != 32'hFFFFFFFF) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  assign instruction_id = if_id.instr;
  assign pc_id          = if_id.pc;
  assign pc_plus4_id    = if_id.pc_plus4;
  assign valid_id       = if_id.valid;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with directed vectors
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr_id;
    logic        valid;
    logic [31:0] pc_id;
    logic [31:0] pc4;
    logic [31:0] fc;
    logic [31:0] iif;
    bit          chk_if;
  } exp_t;

  function automatic logic [64*32-1:0] build_rom();
    logic [31:0]       w [8];
    logic [64*32-1:0]  r;
    w = '{32'h00700093, 32'h00000103, 32'h40208133, 32'h0020F233,
          32'h00500293, 32'h00000313, 32'h00600393, 32'h00700413};
    r = {64{NOP}};
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = w[i];
    return r;
  endfunction

  localparam logic [64*32-1:0] ROM = build_rom();

  logic        clk;
  logic        reset;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        pc_src;
  logic [31:0] branch_target;
  logic [31:0] pc_current;
  logic [31:0] instruction_if;
  logic [31:0] pc_id;
  logic [31:0] pc_plus4_id;
  logic [31:0] instruction_id;
  logic        valid_id;
  logic [31:0] fetch_count;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  event sample_ev;

  if_stage #(
    .IMEM_DEPTH(64),
    .IMEM_INIT (ROM)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .pc_current    (pc_current),
    .instruction_if(instruction_if),
    .pc_id         (pc_id),
    .pc_plus4_id   (pc_plus4_id),
    .instruction_id(instruction_id),
    .valid_id      (valid_id),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t e(input string tag, input logic [31:0] pc,
                             input logic [31:0] id, input logic v,
                             input logic [31:0] pcid, input logic [31:0] fc,
                             input logic [31:0] iif, input bit chk);
    exp_t x;
    x.tag = tag; x.pc = pc; x.instr_id = id; x.valid = v;
    x.pc_id = pcid; x.pc4 = pcid + 32'd4; x.fc = fc; x.iif = iif; x.chk_if = chk;
    return x;
  endfunction

  task automatic cmp(input string tag, input string f,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%08h required=%08h", tag, f, act, req);
    end
  endtask

  // Monitor: compares DUT state against the oldest pending expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        cmp(x.tag, "pc_current", pc_current, x.pc);
        cmp(x.tag, "instruction_id", instruction_id, x.instr_id);
        cmp(x.tag, "valid_id", {31'd0, valid_id}, {31'd0, x.valid});
        cmp(x.tag, "pc_id", pc_id, x.pc_id);
        cmp(x.tag, "pc_plus4_id", pc_plus4_id, x.pc4);
        cmp(x.tag, "fetch_count", fetch_count, x.fc);
        if (x.chk_if) cmp(x.tag, "instruction_if", instruction_if, x.iif);
      end
    end
  end

  task automatic step(input logic pw, input logic iw, input logic fl,
                      input logic src, input logic [31:0] tgt, input exp_t x);
    @(negedge clk);
    reset         = 1'b0;
    pc_write      = pw;
    if_id_write   = iw;
    if_id_flush   = fl;
    pc_src        = src;
    branch_target = tgt;
    q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic check_now(input exp_t x);
    q.push_back(x);
    -> sample_ev;
    #2;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog simulation did not finish, pending=%0d", q.size());
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pc_write = 1'b0; if_id_write = 1'b0;
    if_id_flush = 1'b0; pc_src = 1'b0; branch_target = 32'd0;

    #2;
    check_now(e("reset", 32'h0, NOP, 1'b0, 32'h0, 32'd0, 32'h00700093, 1'b1));
    @(negedge clk);

    step(1, 1, 0, 0, 32'h0, e("fetch1", 32'h4, 32'h00700093, 1, 32'h0, 32'd1, 32'h00000103, 1));
    step(1, 1, 0, 0, 32'h0, e("fetch2", 32'h8, 32'h00000103, 1, 32'h4, 32'd2, 32'h40208133, 1));
    step(0, 0, 0, 0, 32'h0, e("stall", 32'h8, 32'h00000103, 1, 32'h4, 32'd2, 32'h40208133, 1));
    step(1, 1, 0, 0, 32'h0, e("resume", 32'hC, 32'h40208133, 1, 32'h8, 32'd3, 32'h0020F233, 1));
    step(1, 1, 0, 0, 32'h0, e("fetch4", 32'h10, 32'h0020F233, 1, 32'hC, 32'd4, 32'h00500293, 1));
    step(1, 1, 1, 1, 32'h4, e("flush", 32'h4, NOP, 0, 32'hC, 32'd4, 32'h00000103, 1));
    step(1, 1, 0, 0, 32'h0, e("after_flush", 32'h8, 32'h00000103, 1, 32'h4, 32'd5, 32'h40208133, 1));
    step(0, 0, 1, 1, 32'h21, e("flush_stall", 32'h20, NOP, 0, 32'h4, 32'd5, NOP, 1));
    step(1, 1, 0, 1, 32'h12, e("redir_noflush", 32'h10, NOP, 1, 32'h20, 32'd6, 32'h00500293, 1));
    step(1, 1, 0, 0, 32'h0, e("post_redir", 32'h14, 32'h00500293, 1, 32'h10, 32'd7, 32'h00000313, 1));
    step(1, 1, 0, 1, 32'hFC, e("last_word", 32'hFC, 32'h00000313, 1, 32'h14, 32'd8, NOP, 1));
    step(1, 1, 0, 0, 32'h0, e("out_of_range", 32'h100, NOP, 1, 32'hFC, 32'd9, NOP, 1));
    step(1, 1, 0, 1, 32'hFFFFFFFF, e("to_max", 32'hFFFFFFFC, NOP, 1, 32'h100, 32'd10, NOP, 1));
    step(1, 1, 0, 0, 32'h0, e("pc_wrap", 32'h0, NOP, 1, 32'hFFFFFFFC, 32'd11, 32'h00700093, 1));

    reset = 1'b1;
    check_now(e("async_reset", 32'h0, NOP, 0, 32'h0, 32'd0, 32'h00700093, 1));

    step(1, 1, 0, 0, 32'h0, e("post_reset", 32'h4, 32'h00700093, 1, 32'h0, 32'd1, 32'h00000103, 1));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
